// File: rtl/pll_power_seq_if.sv
// Handshake bundle between the PLL power sequencer (master) and the SoC/PLL side (slave).
interface pll_power_seq_if #(
    parameter int NUM_DOMAINS = 2
);
    logic                   wfi;
    logic                   wake;
    logic [NUM_DOMAINS-1:0] domain_mask;
    logic                   pll_lock;
    logic                   pll_resetb;
    logic                   pll_bypass;
    logic                   pll_latch;
    logic [NUM_DOMAINS-1:0] gate_en;
    logic                   sleep_ack;
    logic                   lock_fail;
    logic [2:0]             state_o;
    logic [31:0]            sleep_cycles;

    modport master (
        input  wfi, wake, domain_mask, pll_lock,
        output pll_resetb, pll_bypass, pll_latch, gate_en,
               sleep_ack, lock_fail, state_o, sleep_cycles
    );

    modport slave (
        output wfi, wake, domain_mask, pll_lock,
        input  pll_resetb, pll_bypass, pll_latch, gate_en,
               sleep_ack, lock_fail, state_o, sleep_cycles
    );
endinterface

// File: rtl/pll_power_seq.sv
// PLL boot/lock and WFI clock-gating sequencer, clocked from the always-on HFOSC.
// Optional sleep-length counter is built only when PLL_POWER_SEQ_SLEEP_CNT_EN is defined.
module pll_power_seq #(
    parameter int NUM_DOMAINS  = 2,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic           clk_ref,
    input  logic           rst,
    pll_power_seq_if.master bus
);

    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > DRAIN_CYCLES) ? CNT_MAX_A : DRAIN_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_LOCK   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SLEEP  = 3'd4,
        ST_RELOCK = 3'd5,
        ST_UNGATE = 3'd6
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   lock_meta;
    logic                   lock_sync;
    logic [NUM_DOMAINS-1:0] mask_q;
    logic                   pll_resetb_q;
    logic                   pll_bypass_q;
    logic                   pll_latch_q;
    logic [NUM_DOMAINS-1:0] gate_en_q;
    logic                   sleep_ack_q;
    logic                   lock_fail_q;
    logic                   enter_sleep;

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    assign enter_sleep = (state == ST_DRAIN) && bus.wfi && !bus.wake && (cnt == DRAIN_LAST);

    // LOCK comes straight from the PLL analog block and is unrelated to clk_ref.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state        <= ST_PLLRST;
            cnt          <= '0;
            mask_q       <= '0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b1;
            pll_latch_q  <= 1'b0;
            gate_en_q    <= '1;
            sleep_ack_q  <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            case (state)
                ST_PLLRST: begin
                    if (cnt == RESET_LAST) begin
                        pll_resetb_q <= 1'b1;
                        cnt          <= '0;
                        state        <= ST_LOCK;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // On timeout the core keeps running from REFCLK through the bypass mux.
                ST_LOCK: begin
                    if (lock_sync) begin
                        pll_bypass_q <= 1'b0;
                        state        <= ST_RUN;
                    end else if (cnt == LOCK_LAST) begin
                        lock_fail_q <= 1'b1;
                        state       <= ST_RUN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RUN: begin
                    if (bus.wfi && !bus.wake) begin
                        mask_q <= bus.domain_mask;
                        cnt    <= '0;
                        state  <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (bus.wake || !bus.wfi) begin
                        state <= ST_RUN;
                    end else if (cnt == DRAIN_LAST) begin
                        gate_en_q    <= ~mask_q;
                        pll_bypass_q <= 1'b1;
                        pll_latch_q  <= 1'b1;
                        sleep_ack_q  <= 1'b1;
                        state        <= ST_SLEEP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // A PLL that never locked is not worth relocking; go straight to ungating.
                ST_SLEEP: begin
                    if (bus.wake) begin
                        pll_latch_q <= 1'b0;
                        cnt         <= '0;
                        if (lock_fail_q) begin
                            pll_bypass_q <= 1'b1;
                            state        <= ST_UNGATE;
                        end else begin
                            state <= ST_RELOCK;
                        end
                    end
                end

                ST_RELOCK: begin
                    if (lock_sync) begin
                        pll_bypass_q <= lock_fail_q;
                        state        <= ST_UNGATE;
                    end else if (cnt == LOCK_LAST) begin
                        lock_fail_q  <= 1'b1;
                        pll_bypass_q <= 1'b1;
                        state        <= ST_UNGATE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // Bypass mux settled last edge; only now release the gated clocks.
                ST_UNGATE: begin
                    gate_en_q   <= '1;
                    sleep_ack_q <= 1'b0;
                    state       <= ST_RUN;
                end

                // Corrupted state: restart the whole boot with safe PLL controls.
                default: begin
                    cnt          <= '0;
                    pll_resetb_q <= 1'b0;
                    pll_bypass_q <= 1'b1;
                    pll_latch_q  <= 1'b0;
                    gate_en_q    <= '1;
                    sleep_ack_q  <= 1'b0;
                    state        <= ST_PLLRST;
                end
            endcase
        end
    end

`ifdef PLL_POWER_SEQ_SLEEP_CNT_EN
    logic [31:0] sleep_cnt;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            sleep_cnt <= '0;
        end else if (enter_sleep) begin
            sleep_cnt <= '0;
        end else if (state == ST_SLEEP && !(&sleep_cnt)) begin
            sleep_cnt <= sleep_cnt + 32'd1;
        end
    end

    assign bus.sleep_cycles = sleep_cnt;
`else
    logic unused_enter_sleep;
    assign unused_enter_sleep = enter_sleep;
    assign bus.sleep_cycles   = '0;
`endif

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.pll_bypass = pll_bypass_q;
    assign bus.pll_latch  = pll_latch_q;
    assign bus.gate_en    = gate_en_q;
    assign bus.sleep_ack  = sleep_ack_q;
    assign bus.lock_fail  = lock_fail_q;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_pll_power_seq.sv
// Directed bench for pll_power_seq: boot, lock timeout, sleep/wake, abort, race and reset mid-sleep.
module tb_pll_power_seq;

    localparam int ND = 2;

`ifdef PLL_POWER_SEQ_SLEEP_CNT_EN
    localparam logic [31:0] EXP_SLEEP = 32'd100;
`else
    localparam logic [31:0] EXP_SLEEP = 32'd0;
`endif

    logic clk_ref = 1'b0;
    logic rst     = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pll_power_seq_if #(.NUM_DOMAINS(ND)) bus ();

    pll_power_seq #(
        .NUM_DOMAINS (ND),
        .RESET_CYCLES(16),
        .LOCK_TIMEOUT(64),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk_ref(clk_ref),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic k, input logic [ND-1:0] m);
        bus.wfi         = w;
        bus.wake        = k;
        bus.domain_mask = m;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_ref);
            #1;
        end
    endtask

    task automatic waitState(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.state_o !== target && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(bus.state_o), 32'(target));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_resetb"}, 32'(bus.pll_resetb),   32'd0);
        checkOutput({tag, "_bypass"}, 32'(bus.pll_bypass),   32'd1);
        checkOutput({tag, "_latch"},  32'(bus.pll_latch),    32'd0);
        checkOutput({tag, "_gate"},   32'(bus.gate_en),      32'h3);
        checkOutput({tag, "_ack"},    32'(bus.sleep_ack),    32'd0);
        checkOutput({tag, "_fail"},   32'(bus.lock_fail),    32'd0);
        checkOutput({tag, "_scyc"},   bus.sleep_cycles,      32'd0);
        checkOutput({tag, "_state"},  32'(bus.state_o),      32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 2'b00);
        bus.pll_lock = 1'b0;
        step(3);
        checkResetValues("por");
        @(negedge clk_ref);
        rst = 1'b0;

        // Boot: resetb low for 16 edges, lock raised after edge 40
        step(15);
        checkOutput("boot_resetb_lo", 32'(bus.pll_resetb), 32'd0);
        step(1);
        checkOutput("boot_resetb_hi", 32'(bus.pll_resetb), 32'd1);
        checkOutput("boot_state_lock", 32'(bus.state_o), 32'd1);
        step(24);
        checkOutput("boot_wait_state", 32'(bus.state_o), 32'd1);
        checkOutput("boot_wait_bypass", 32'(bus.pll_bypass), 32'd1);
        bus.pll_lock = 1'b1;
        waitState("boot_run", 3'd2, 3);
        checkOutput("boot_bypass", 32'(bus.pll_bypass), 32'd0);
        checkOutput("boot_fail", 32'(bus.lock_fail), 32'd0);

        // Race: wfi and wake together keep the sequencer in RUN
        applyStimulus(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checkOutput("race_state", 32'(bus.state_o), 32'd2);
        end

        // Abort: wake in the second DRAIN cycle
        applyStimulus(1'b1, 1'b0, 2'b11);
        step(1);
        checkOutput("abort_drain1", 32'(bus.state_o), 32'd3);
        step(1);
        checkOutput("abort_drain2", 32'(bus.state_o), 32'd3);
        checkOutput("abort_latch_d", 32'(bus.pll_latch), 32'd0);
        applyStimulus(1'b1, 1'b1, 2'b11);
        step(1);
        checkOutput("abort_state", 32'(bus.state_o), 32'd2);
        checkOutput("abort_gate", 32'(bus.gate_en), 32'h3);
        checkOutput("abort_latch", 32'(bus.pll_latch), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        step(2);
        checkOutput("abort_latch_after", 32'(bus.pll_latch), 32'd0);

        // Sleep with mask 10, 100 cycles asleep, then relock
        applyStimulus(1'b1, 1'b0, 2'b10);
        step(1);
        checkOutput("sleep_drain", 32'(bus.state_o), 32'd3);
        step(3);
        checkOutput("sleep_drain_last", 32'(bus.state_o), 32'd3);
        checkOutput("sleep_drain_gate", 32'(bus.gate_en), 32'h3);
        step(1);
        checkOutput("sleep_state", 32'(bus.state_o), 32'd4);
        checkOutput("sleep_gate", 32'(bus.gate_en), 32'h1);
        checkOutput("sleep_bypass", 32'(bus.pll_bypass), 32'd1);
        checkOutput("sleep_latch", 32'(bus.pll_latch), 32'd1);
        checkOutput("sleep_ack", 32'(bus.sleep_ack), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b00);
        bus.pll_lock = 1'b0;
        step(99);
        checkOutput("sleep_hold", 32'(bus.state_o), 32'd4);
        checkOutput("sleep_hold_gate", 32'(bus.gate_en), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'b00);
        step(1);
        checkOutput("wake_state", 32'(bus.state_o), 32'd5);
        checkOutput("wake_latch", 32'(bus.pll_latch), 32'd0);
        checkOutput("wake_bypass", 32'(bus.pll_bypass), 32'd1);
        checkOutput("wake_gate", 32'(bus.gate_en), 32'h1);
        checkOutput("wake_scyc", bus.sleep_cycles, EXP_SLEEP);
        bus.pll_lock = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00);
        waitState("relock_ungate", 3'd6, 4);
        checkOutput("ungate_bypass", 32'(bus.pll_bypass), 32'd0);
        checkOutput("ungate_gate", 32'(bus.gate_en), 32'h1);
        checkOutput("ungate_ack", 32'(bus.sleep_ack), 32'd1);
        step(1);
        checkOutput("resume_state", 32'(bus.state_o), 32'd2);
        checkOutput("resume_gate", 32'(bus.gate_en), 32'h3);
        checkOutput("resume_ack", 32'(bus.sleep_ack), 32'd0);
        checkOutput("resume_scyc", bus.sleep_cycles, EXP_SLEEP);

        // Reset mid-sleep, asserted between clock edges
        applyStimulus(1'b1, 1'b0, 2'b01);
        waitState("sleep2_enter", 3'd4, 8);
        checkOutput("sleep2_gate", 32'(bus.gate_en), 32'h2);
        step(3);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midsleep");
        applyStimulus(1'b0, 1'b0, 2'b00);
        bus.pll_lock = 1'b0;
        @(negedge clk_ref);
        rst = 1'b0;

        // Reboot without lock: timeout at edge 16+64
        step(16);
        checkOutput("tmo_resetb", 32'(bus.pll_resetb), 32'd1);
        step(63);
        checkOutput("tmo_pre_fail", 32'(bus.lock_fail), 32'd0);
        checkOutput("tmo_pre_state", 32'(bus.state_o), 32'd1);
        step(1);
        checkOutput("tmo_fail", 32'(bus.lock_fail), 32'd1);
        checkOutput("tmo_state", 32'(bus.state_o), 32'd2);
        checkOutput("tmo_bypass", 32'(bus.pll_bypass), 32'd1);

        // Sleep after a failed lock skips relock and keeps REFCLK
        applyStimulus(1'b1, 1'b0, 2'b11);
        waitState("fsleep_enter", 3'd4, 8);
        checkOutput("fsleep_gate", 32'(bus.gate_en), 32'h0);
        checkOutput("fsleep_latch", 32'(bus.pll_latch), 32'd1);
        applyStimulus(1'b0, 1'b1, 2'b00);
        step(1);
        checkOutput("fwake_state", 32'(bus.state_o), 32'd6);
        checkOutput("fwake_bypass", 32'(bus.pll_bypass), 32'd1);
        checkOutput("fwake_latch", 32'(bus.pll_latch), 32'd0);
        checkOutput("fwake_gate", 32'(bus.gate_en), 32'h0);
        step(1);
        checkOutput("fresume_state", 32'(bus.state_o), 32'd2);
        checkOutput("fresume_gate", 32'(bus.gate_en), 32'h3);
        checkOutput("fresume_ack", 32'(bus.sleep_ack), 32'd0);
        checkOutput("fresume_bypass", 32'(bus.pll_bypass), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
